alu_ctrl_fsm: RTL

ALU_CTRL_FSM -- requirements
Module: alu_ctrl_fsm

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_op_decode.sv | 53 +++++
 rtl/alu_ctrl_fsm.sv | 112 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the accumulator controller and ALU:
//               opcode constants, the ALU select value used when no
//               operation is being issued, and the controller state type.
// Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    // Instruction opcodes (4-bit instruction field)
    localparam logic [3:0] c_OP_CLR  = 4'd0;
    localparam logic [3:0] c_OP_PASS = 4'd1;
    localparam logic [3:0] c_OP_ADD  = 4'd2;
    localparam logic [3:0] c_OP_SUB  = 4'd3;
    localparam logic [3:0] c_OP_MUL  = 4'd4;
    localparam logic [3:0] c_OP_INC  = 4'd5;
    localparam logic [3:0] c_OP_NOP  = 4'd6;

    // ALU select value presented whenever no operation is being issued
    localparam logic [2:0] c_ALU_SEL_IDLE = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_decode
// Description : Opcode decoder. Maps a 4-bit opcode to the ALU select,
//               a legality flag and an accumulator write enable.
//               Optional feature macro: ALU_CTRL_MUL_EN (opcode 4 = multiply
//               is legal only when defined).
// Ports       : i_opcode     - opcode to decode
//               o_alu_sel    - ALU operation select (idle value if none)
//               o_legal      - opcode is a legal instruction
//               o_writes_ac  - instruction writes the accumulator
// Revision    : 1.0  initial release
// ============================================================================
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [3:0] i_opcode,
    output logic [2:0] o_alu_sel,
    output logic       o_legal,
    output logic       o_writes_ac
);

    always_comb begin
        o_alu_sel   = c_ALU_SEL_IDLE;
        o_legal     = 1'b0;
        o_writes_ac = 1'b0;
        case (i_opcode)
            c_OP_CLR, c_OP_PASS, c_OP_ADD, c_OP_SUB, c_OP_INC: begin
                // ALU select encoding matches the opcode for these ops
                o_alu_sel   = i_opcode[2:0];
                o_legal     = 1'b1;
                o_writes_ac = 1'b1;
            end
`ifdef ALU_CTRL_MUL_EN
            c_OP_MUL: begin
                o_alu_sel   = 3'd4;
                o_legal     = 1'b1;
                o_writes_ac = 1'b1;
            end
`endif
            c_OP_NOP: begin
                // Legal, but the ALU is left on its idle select
                o_legal     = 1'b1;
            end
            default: begin
                // Illegal opcode (includes multiply when not built in)
                o_legal     = 1'b0;
            end
        endcase
    end

endmodule : alu_op_decode
`default_nettype wire

// File: rtl/alu_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_fsm
// Description : Accumulator controller driving an external combinational ALU.
//               Accepts one instruction per valid/ready handshake, issues it
//               to the ALU for exactly one cycle, loads the accumulator and
//               pulses done (and err for an illegal opcode).
//               Optional feature macro: ALU_CTRL_MUL_EN (enables multiply).
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               instr_valid/ready, instr_op, instr_operand - instruction in
//               alu_a, alu_b, alu_sel, alu_result - ALU interface
//               ac_out          - accumulator value
//               done, err       - completion / illegal-opcode pulses
// Revision    : 1.0  initial release
// ============================================================================
module alu_ctrl_fsm
    import alu_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [3:0]       instr_op,
    input  logic [WIDTH-1:0] instr_operand,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] ac_out,
    output logic             done,
    output logic             err
);

    state_t           r_state;
    logic [WIDTH-1:0] r_ac;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_operand;
    logic             r_ready;
    logic             r_done;
    logic             r_err;

    logic [2:0]       w_dec_sel;
    logic             w_dec_legal;
    logic             w_dec_writes_ac;
    logic             w_handshake;

    // Decode works on the latched opcode, so it is stable through EXEC
    alu_op_decode u_decode (
        .i_opcode    (r_op),
        .o_alu_sel   (w_dec_sel),
        .o_legal     (w_dec_legal),
        .o_writes_ac (w_dec_writes_ac)
    );

    // r_ready is only high in IDLE/DONE, so inputs are never sampled in EXEC
    assign w_handshake = instr_valid && r_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ac      <= '0;
            r_op      <= '0;
            r_operand <= '0;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    r_err  <= 1'b0;
                    if (w_handshake) begin
                        r_op      <= instr_op;
                        r_operand <= instr_operand;
                        r_ready   <= 1'b0;
                        r_state   <= ST_EXEC;
                    end else begin
                        r_ready   <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    if (w_dec_writes_ac) begin
                        r_ac <= alu_result;
                    end
                    r_done  <= 1'b1;
                    r_err   <= ~w_dec_legal;
                    r_ready <= 1'b1;
                    r_state <= ST_DONE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign instr_ready = r_ready;
    assign done        = r_done;
    assign err         = r_err;
    assign ac_out      = r_ac;
    assign alu_a       = r_ac;
    assign alu_b       = r_operand;
    assign alu_sel     = (r_state == ST_EXEC) ? w_dec_sel : c_ALU_SEL_IDLE;

endmodule : alu_ctrl_fsm
`default_nettype wire
